// File: rtl/spi_codec_cfg_seq_if.sv
// Bus bundle for the codec register-initialisation sequencer.
// Groups the host handshake, the table-memory port and the SPI pins so the
// sequencer and its environment connect through one port.
//   master : sequencer side (drives the o* signals)
//   slave  : environment side (drives iSTART, iTBL_DATA, iDOUT)
interface spi_codec_cfg_seq_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int TBL_AW = 7
);
  // host handshake / status
  logic                     iSTART;
  logic                     oBUSY;
  logic                     oDONE;
  logic                     oERR;
  logic [TBL_AW-1:0]        oERR_IDX;
  logic [DATA_W-1:0]        oRD_DATA;
  logic                     oRD_VALID;
  // table memory port
  logic [TBL_AW-1:0]        oTBL_ADDR;
  logic [ADDR_W+DATA_W-1:0] iTBL_DATA;
  // SPI pins
  logic                     oCS_n;
  logic                     oSCLK;
  logic                     oDIN;
  logic                     iDOUT;

  modport master (
    input  iSTART, iTBL_DATA, iDOUT,
    output oBUSY, oDONE, oERR, oERR_IDX, oRD_DATA, oRD_VALID,
           oTBL_ADDR, oCS_n, oSCLK, oDIN
  );

  modport slave (
    output iSTART, iTBL_DATA, iDOUT,
    input  oBUSY, oDONE, oERR, oERR_IDX, oRD_DATA, oRD_VALID,
           oTBL_ADDR, oCS_n, oSCLK, oDIN
  );
endinterface

// File: rtl/spi_codec_cfg_seq.sv
// SPI register-initialisation sequencer for audio codecs.
// Walks an external table of {addr, data} words; for each entry it shifts out
// a write frame {addr, 0, data}, optionally reads the register back with a
// frame {addr, 1, ones}, compares, and retries on mismatch. An entry whose
// address field is all ones ends the table early.
// Ports:
//   iCLK_50  : system clock
//   iRESET_n : asynchronous active-low reset
//   bus      : master side of spi_codec_cfg_seq_if (start/status, table port,
//              SPI pins oCS_n/oSCLK/oDIN/iDOUT)
module spi_codec_cfg_seq #(
  parameter int CLK_DIV  = 63,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int TBL_AW   = 7,
  parameter int WORD_NUM = 128,
  parameter int VERIFY   = 1,
  parameter int RETRY    = 2
) (
  input logic                 iCLK_50,
  input logic                 iRESET_n,
  spi_codec_cfg_seq_if.master bus
);

  localparam int FW   = ADDR_W + 1 + DATA_W;            // frame length in bits
  localparam int BCW  = $clog2(FW + 1);                 // holds 0..FW
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, WR_FRAME, GAP, RD_FRAME, CHECK, NEXT, FIN
  } state_t;

  // ---------------------------------------------------------------------------
  // Free-running tick divider: one-cycle strobe every CLK_DIV clocks
  // ---------------------------------------------------------------------------
  logic [DIVW-1:0] div_q;
  logic            tick;

  assign tick = (div_q == DIVW'(CLK_DIV - 1));

  always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
    if (!iRESET_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [TBL_AW-1:0] err_idx_q;
  logic [TBL_AW-1:0] tbl_addr_q;
  logic [TBL_AW-1:0] idx_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              cs_n_q;
  logic              sclk_q;
  logic              din_q;
  logic [2:0]        retry_q;
  logic              fetch_q;     // FETCH wait: 0 = address out, 1 = data arriving
  logic [ADDR_W-1:0] ent_addr_q;
  logic [DATA_W-1:0] ent_data_q;
  logic [FW-1:0]     shift_q;     // outgoing frame, MSB first
  logic [DATA_W-1:0] cap_q;       // last DATA_W bits seen on iDOUT
  logic [BCW-1:0]    bit_q;       // bits completed in the current frame
  logic              phase_q;     // 0 = next tick is falling edge, 1 = rising
  logic              lead_q;      // one idle tick before the first bit
  logic              gap_q;

  always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
    if (!iRESET_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      tbl_addr_q <= '0;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      din_q      <= 1'b0;
      retry_q    <= '0;
      fetch_q    <= 1'b0;
      ent_addr_q <= '0;
      ent_data_q <= '0;
      shift_q    <= '0;
      cap_q      <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      lead_q     <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.iSTART) begin
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            tbl_addr_q <= '0;
            fetch_q    <= 1'b0;
            state_q    <= FETCH;
          end
        end

        // Table is synchronous: data valid one clock after the address, so
        // latch on the second cycle in this state.
        FETCH: begin
          if (fetch_q) begin
            ent_addr_q <= bus.iTBL_DATA[ADDR_W+DATA_W-1:DATA_W];
            ent_data_q <= bus.iTBL_DATA[DATA_W-1:0];
            state_q    <= LOAD;
          end else begin
            fetch_q <= 1'b1;
          end
        end

        LOAD: begin
          if (&ent_addr_q) begin
            state_q <= FIN;
          end else begin
            shift_q <= {ent_addr_q, 1'b0, ent_data_q};
            bit_q   <= '0;
            phase_q <= 1'b0;
            lead_q  <= 1'b1;
            state_q <= WR_FRAME;
          end
        end

        // Both frame types share the shifter. The lead tick keeps CS high for
        // at least two ticks between back-to-back frames (retries, next entry).
        WR_FRAME, RD_FRAME: begin
          if (tick) begin
            if (lead_q) begin
              lead_q <= 1'b0;
            end else if (!phase_q) begin
              if (bit_q == BCW'(FW)) begin
                // closing tick: release CS, park SCLK high
                cs_n_q <= 1'b1;
                sclk_q <= 1'b1;
                din_q  <= 1'b0;
                if (state_q == WR_FRAME) begin
                  gap_q   <= 1'b0;
                  state_q <= GAP;
                end else begin
                  rd_data_q  <= cap_q;
                  rd_valid_q <= 1'b1;
                  state_q    <= CHECK;
                end
              end else begin
                cs_n_q  <= 1'b0;
                sclk_q  <= 1'b0;
                din_q   <= shift_q[FW-1];
                shift_q <= {shift_q[FW-2:0], 1'b0};
                phase_q <= 1'b1;
              end
            end else begin
              sclk_q  <= 1'b1;
              cap_q   <= {cap_q[DATA_W-2:0], bus.iDOUT};
              bit_q   <= bit_q + 1'b1;
              phase_q <= 1'b0;
            end
          end
        end

        GAP: begin
          if (tick) begin
            if (gap_q) begin
              if (VERIFY == 0) begin
                state_q <= NEXT;
              end else begin
                shift_q <= {ent_addr_q, 1'b1, {DATA_W{1'b1}}};
                bit_q   <= '0;
                phase_q <= 1'b0;
                lead_q  <= 1'b1;
                state_q <= RD_FRAME;
              end
            end else begin
              gap_q <= 1'b1;
            end
          end
        end

        CHECK: begin
          if (rd_data_q == ent_data_q) begin
            state_q <= NEXT;
          end else if (retry_q < 3'(RETRY)) begin
            // rewrite the same entry without refetching it
            retry_q <= retry_q + 1'b1;
            shift_q <= {ent_addr_q, 1'b0, ent_data_q};
            bit_q   <= '0;
            phase_q <= 1'b0;
            lead_q  <= 1'b1;
            state_q <= WR_FRAME;
          end else begin
            // only the first exhausted entry is recorded
            if (!err_q) begin
              err_q     <= 1'b1;
              err_idx_q <= idx_q;
            end
            state_q <= NEXT;
          end
        end

        NEXT: begin
          retry_q <= '0;
          if (idx_q == TBL_AW'(WORD_NUM - 1)) begin
            state_q <= FIN;
          end else begin
            idx_q      <= idx_q + 1'b1;
            tbl_addr_q <= idx_q + 1'b1;
            fetch_q    <= 1'b0;
            state_q    <= FETCH;
          end
        end

        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oBUSY     = busy_q;
  assign bus.oDONE     = done_q;
  assign bus.oERR      = err_q;
  assign bus.oERR_IDX  = err_idx_q;
  assign bus.oTBL_ADDR = tbl_addr_q;
  assign bus.oRD_DATA  = rd_data_q;
  assign bus.oRD_VALID = rd_valid_q;
  assign bus.oCS_n     = cs_n_q;
  assign bus.oSCLK     = sclk_q;
  assign bus.oDIN      = din_q;

endmodule

// File: tb/tb_spi_codec_cfg_seq.sv
// Directed bench for spi_codec_cfg_seq. Two instances share one table:
//   g_inst[0]: CLK_DIV=4, VERIFY=1, RETRY=2, WORD_NUM=128 (table ends at entry 4)
//   g_inst[1]: CLK_DIV=2, VERIFY=0, WORD_NUM=3 (no terminator reached)
// Each instance has a codec model that records frames and echoes registers.
module tb_spi_codec_cfg_seq;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int TBL_AW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W+DATA_W-1:0] tbl [0:127];
  logic [1:0]  start = 2'b00;
  logic [1:0]  done_w;
  logic [6:0]  corrupt_addr = 7'h10;
  int          corrupt_lim = 0;
  int          caddr_base = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int CDIV = (gi == 0) ? 4 : 2;

    spi_codec_cfg_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TBL_AW(TBL_AW)) bus ();

    spi_codec_cfg_seq #(
      .CLK_DIV (CDIV),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TBL_AW  (TBL_AW),
      .WORD_NUM((gi == 0) ? 128 : 3),
      .VERIFY  ((gi == 0) ? 1 : 0),
      .RETRY   (2)
    ) dut (
      .iCLK_50 (clk),
      .iRESET_n(rst_n),
      .bus     (bus)
    );

    assign bus.iSTART = start[gi];
    assign done_w[gi] = bus.oDONE;

    always @(posedge clk) bus.iTBL_DATA <= tbl[bus.oTBL_ADDR];

    // codec model; all statistics are monotonic, the main block uses deltas
    logic [7:0]  regs [0:127];
    logic [15:0] frame_log [0:255];
    logic [7:0]  rdv_log [0:255];
    logic [15:0] sh = '0;
    logic [7:0]  rd_val = '0;
    logic        rw = 1'b0;
    logic        dout = 1'b0;
    int          bitn = 0;
    int          n_frames = 0;
    int          n_rd = 0;
    int          n_cwr = 0;
    int          n_rdv = 0;
    int          n_lowbad = 0;
    int          n_shortgap = 0;
    int          n_caddr_rd = 0;
    int          sclk_per = 0;
    time         t_cs_fall = 0;
    time         t_cs_rise = 0;
    time         t_sclk_fall = 0;

    assign bus.iDOUT = dout;

    always @(negedge bus.oCS_n) begin
      if (t_cs_rise != 0 && int'((($time - t_cs_rise) / 10)) < 2 * CDIV) n_shortgap++;
      t_cs_fall = $time;
      bitn = 0;
      sh = '0;
    end

    always @(posedge bus.oCS_n) begin
      t_cs_rise = $time;
      if (bitn == 16) begin
        if (int'((($time - t_cs_fall) / 10)) != 32 * CDIV) n_lowbad++;
        if (n_frames < 256) frame_log[n_frames] = sh;
        n_frames++;
        if (sh[8]) begin
          n_rd++;
        end else begin
          regs[sh[15:9]] = sh[7:0];
          if (sh[15:9] == corrupt_addr) n_cwr++;
        end
      end
      bitn = 0;
      dout = 1'b0;
    end

    always @(posedge bus.oSCLK) begin
      if (!bus.oCS_n) begin
        sh = {sh[14:0], bus.oDIN};
        bitn++;
        if (bitn == 8) begin
          rw = sh[0];
          rd_val = regs[sh[7:1]];
          if (rw && sh[7:1] == corrupt_addr) begin
            if (n_caddr_rd - caddr_base < corrupt_lim) rd_val = ~rd_val;
            n_caddr_rd++;
          end
        end
      end
    end

    always @(negedge bus.oSCLK) begin
      if (!bus.oCS_n) begin
        if (bitn > 0) sclk_per = int'((($time - t_sclk_fall) / 10));
        t_sclk_fall = $time;
        if (bitn >= 8 && rw) dout = rd_val[15 - bitn];
        else dout = 1'b0;
      end
    end

    always @(negedge clk) begin
      if (bus.oRD_VALID) begin
        if (n_rdv < 256) rdv_log[n_rdv] = bus.oRD_DATA;
        n_rdv++;
      end
    end
  end

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input string tag);
    int n;
    n = 0;
    while (!done_w[i] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done_w[i]), 32'd1);
  endtask

  int b, br, bc, bl, bs, n;
  logic [15:0] exp_fr [0:11];
  logic [7:0]  exp_rd [0:5];

  initial begin
    for (int i = 0; i < 128; i++) tbl[i] = {7'h7F, 8'h00};
    tbl[0] = {7'h04, 8'h15};
    tbl[1] = {7'h05, 8'hA3};
    tbl[2] = {7'h10, 8'h3C};
    tbl[3] = {7'h22, 8'hC7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pins", {29'd0, g_inst[0].bus.oCS_n, g_inst[0].bus.oSCLK, g_inst[0].bus.oDIN}, 32'd6);
    chk("rst_flags", {29'd0, g_inst[0].bus.oBUSY, g_inst[0].bus.oDONE, g_inst[0].bus.oERR}, 32'd0);
    chk("rst_addr", {25'd0, g_inst[0].bus.oTBL_ADDR}, 32'd0);
    chk("rst_rd", {23'd0, g_inst[0].bus.oRD_VALID, g_inst[0].bus.oRD_DATA}, 32'd0);
    rst_n = 1'b1;

    // ---- run 1: clean echo, plus a start pulse while busy ----
    b = g_inst[0].n_frames; br = g_inst[0].n_rdv; bl = g_inst[0].n_lowbad; bs = g_inst[0].n_shortgap;
    pulse_start(0);
    chk("run1_busy", {30'd0, g_inst[0].bus.oBUSY, g_inst[0].bus.oDONE}, 32'd2);
    n = 0;
    while (g_inst[0].n_frames == b && n < 5000) begin @(negedge clk); n++; end
    pulse_start(0);
    wait_done(0, "run1_done");
    exp_fr[0] = 16'h0815; exp_fr[1] = 16'h09FF; exp_fr[2] = 16'h0AA3; exp_fr[3] = 16'h0BFF;
    exp_fr[4] = 16'h203C; exp_fr[5] = 16'h21FF; exp_fr[6] = 16'h44C7; exp_fr[7] = 16'h45FF;
    chk("run1_nframes", 32'(g_inst[0].n_frames - b), 32'd8);
    for (int k = 0; k < 8; k++) chk($sformatf("run1_frame%0d", k), 32'(g_inst[0].frame_log[b + k]), 32'(exp_fr[k]));
    chk("run1_nrdv", 32'(g_inst[0].n_rdv - br), 32'd4);
    chk("run1_rd0", 32'(g_inst[0].rdv_log[br]), 32'h15);
    chk("run1_err", {31'd0, g_inst[0].bus.oERR}, 32'd0);
    chk("run1_busy_end", {31'd0, g_inst[0].bus.oBUSY}, 32'd0);
    chk("sclk_period", 32'(g_inst[0].sclk_per), 32'd8);
    chk("cs_low_len_bad", 32'(g_inst[0].n_lowbad - bl), 32'd0);
    chk("cs_gap_short", 32'(g_inst[0].n_shortgap - bs), 32'd0);

    // ---- run 2: entry 2 corrupted twice, third attempt passes ----
    b = g_inst[0].n_frames; br = g_inst[0].n_rdv; bc = g_inst[0].n_cwr; bs = g_inst[0].n_shortgap;
    caddr_base = g_inst[0].n_caddr_rd; corrupt_lim = 2;
    pulse_start(0);
    chk("run2_restart", {30'd0, g_inst[0].bus.oBUSY, g_inst[0].bus.oDONE}, 32'd2);
    wait_done(0, "run2_done");
    chk("run2_nframes", 32'(g_inst[0].n_frames - b), 32'd12);
    chk("run2_wr_entry2", 32'(g_inst[0].n_cwr - bc), 32'd3);
    chk("run2_err", {31'd0, g_inst[0].bus.oERR}, 32'd0);
    exp_rd[0] = 8'h15; exp_rd[1] = 8'hA3; exp_rd[2] = 8'hC3;
    exp_rd[3] = 8'hC3; exp_rd[4] = 8'h3C; exp_rd[5] = 8'hC7;
    chk("run2_nrdv", 32'(g_inst[0].n_rdv - br), 32'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("run2_rd%0d", k), 32'(g_inst[0].rdv_log[br + k]), 32'(exp_rd[k]));
    chk("run2_gap_short", 32'(g_inst[0].n_shortgap - bs), 32'd0);

    // ---- run 3: entry 2 corrupted three times, retries exhausted ----
    b = g_inst[0].n_frames; bc = g_inst[0].n_cwr;
    caddr_base = g_inst[0].n_caddr_rd; corrupt_lim = 3;
    pulse_start(0);
    wait_done(0, "run3_done");
    chk("run3_nframes", 32'(g_inst[0].n_frames - b), 32'd12);
    chk("run3_wr_entry2", 32'(g_inst[0].n_cwr - bc), 32'd3);
    chk("run3_err", {31'd0, g_inst[0].bus.oERR}, 32'd1);
    chk("run3_err_idx", {25'd0, g_inst[0].bus.oERR_IDX}, 32'd2);
    chk("run3_last_frame", 32'(g_inst[0].frame_log[b + 11]), 32'h45FF);
    corrupt_lim = 0;

    // ---- run 4: reset during bit 7 of the first frame, then restart ----
    pulse_start(0);
    chk("run4_err_clear", {31'd0, g_inst[0].bus.oERR}, 32'd0);
    n = 0;
    while (!(g_inst[0].bitn == 7 && !g_inst[0].bus.oCS_n) && n < 5000) begin @(negedge clk); n++; end
    chk("bit7_reached", 32'(g_inst[0].bitn), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pins", {29'd0, g_inst[0].bus.oCS_n, g_inst[0].bus.oSCLK, g_inst[0].bus.oDIN}, 32'd6);
    chk("abort_flags", {29'd0, g_inst[0].bus.oBUSY, g_inst[0].bus.oDONE, g_inst[0].bus.oERR}, 32'd0);
    chk("abort_rd", {23'd0, g_inst[0].bus.oRD_VALID, g_inst[0].bus.oRD_DATA}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b = g_inst[0].n_frames;
    pulse_start(0);
    wait_done(0, "run4_done");
    chk("run4_nframes", 32'(g_inst[0].n_frames - b), 32'd8);
    chk("run4_first_frame", 32'(g_inst[0].frame_log[b]), 32'h0815);

    // ---- write-only instance, three entries, no terminator ----
    b = g_inst[1].n_frames; br = g_inst[1].n_rdv; bl = g_inst[1].n_lowbad;
    pulse_start(1);
    wait_done(1, "wo_done");
    chk("wo_nframes", 32'(g_inst[1].n_frames - b), 32'd3);
    chk("wo_frame0", 32'(g_inst[1].frame_log[b]), 32'h0815);
    chk("wo_frame1", 32'(g_inst[1].frame_log[b + 1]), 32'h0AA3);
    chk("wo_frame2", 32'(g_inst[1].frame_log[b + 2]), 32'h203C);
    chk("wo_nread", 32'(g_inst[1].n_rd), 32'd0);
    chk("wo_nrdv", 32'(g_inst[1].n_rdv - br), 32'd0);
    chk("wo_cs_low_bad", 32'(g_inst[1].n_lowbad - bl), 32'd0);
    chk("wo_sclk_period", 32'(g_inst[1].sclk_per), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_codec_cfg_seq.md
Name: spi_codec_cfg_seq

Overview:
Parametrised SPI register-initialisation sequencer for audio codecs on the DECA target.
- Walks a register table held outside the block. For each entry it shifts out a write frame, reads the register back and checks the value.
- Retries an entry on mismatch, up to a set limit.
- Supports a re-run trigger and early end-of-table.
- Reports progress and errors to the host logic.
- Sits between the board-level codec pins and a synchronous table ROM/RAM.

Parameters:
CLK_DIV, 63, iCLK_50 cycles per SPI half-bit "tick" (>=1)
ADDR_W, 7, register address field width in a frame
DATA_W, 8, register data field width in a frame (frame = ADDR_W+1+DATA_W bits)
TBL_AW, 7, table address width
WORD_NUM, 128, number of table entries processed (<= 2**TBL_AW)
VERIFY, 1, 1 = readback and compare after each write; 0 = write only
RETRY, 2, extra write attempts per entry after a mismatch (0..7)

Ports:
iCLK_50  in  1  system clock
iRESET_n  in  1  asynchronous active-low reset
iSTART  in  1  one-cycle pulse; starts a sequence when idle
oBUSY  out  1  high from accepted start until done
oDONE  out  1  sticky high after completion; cleared by next accepted start
oERR  out  1  sticky: at least one entry failed verify after all retries
oERR_IDX  out  TBL_AW  index of first failing entry
oTBL_ADDR  out  TBL_AW  table read address
iTBL_DATA  in  ADDR_W+DATA_W  table word {addr, data}; valid 1 iCLK_50 after oTBL_ADDR changes
oRD_DATA  out  DATA_W  last readback data
oRD_VALID  out  1  one-cycle pulse when oRD_DATA updates
oCS_n  out  1  SPI chip select, active low
oSCLK  out  1  SPI clock, idle high
oDIN  out  1  SPI data to codec
iDOUT  in  1  SPI data from codec

Behaviour:
- Reset state (async, iRESET_n low): oCS_n=1, oSCLK=1, oDIN=0, oBUSY=0, oDONE=0, oERR=0, oERR_IDX=0, oTBL_ADDR=0, oRD_DATA=0, oRD_VALID=0, FSM=IDLE, tick divider=0. Reset mid-frame aborts immediately to this state.
- Tick: free-running divider, one-cycle strobe every CLK_DIV iCLK_50 cycles. All SPI pin changes happen only on tick strobes.
- FSM states: IDLE, FETCH, LOAD, WR_FRAME, GAP, RD_FRAME, CHECK, NEXT, FIN.
- IDLE: iSTART -> FETCH. Also sets oBUSY=1, clears oDONE/oERR/oERR_IDX, index=0, retry count=0. iSTART in any other state is ignored.
- FETCH: drive oTBL_ADDR=index; wait 2 iCLK_50 cycles; latch iTBL_DATA -> LOAD.
- LOAD: if latched addr field is all ones, treat it as end-of-table -> FIN. Else build write frame {addr, 1'b0, data} -> WR_FRAME.
- Frame shift (WR_FRAME, RD_FRAME), MSB first, 2 ticks per bit:
  - First tick: oCS_n=0 (asserted on the first bit), oSCLK=0, oDIN=next bit.
  - Second tick: oSCLK=1, shift iDOUT into the capture register.
  - After the last bit: one tick with oCS_n=1, oSCLK=1.
- WR_FRAME -> GAP. GAP holds CS high for 2 ticks.
- GAP exit: if VERIFY=0 -> NEXT; else -> RD_FRAME with frame {addr, 1'b1, all-ones}.
- RD_FRAME -> CHECK. On entry to CHECK: oRD_DATA = low DATA_W bits of the capture register; oRD_VALID pulses 1 cycle.
- CHECK:
  - Match -> NEXT.
  - Mismatch with retry<RETRY -> retry+1, back to WR_FRAME (same entry, no refetch).
  - Mismatch with retry==RETRY -> NEXT. If oERR=0, set oERR=1 and oERR_IDX=index. Later failures do not overwrite oERR_IDX.
- NEXT: retry=0. If index==WORD_NUM-1 -> FIN; else index+1 -> FETCH.
- FIN: oBUSY=0, oDONE=1 -> IDLE. Re-run with a new iSTART is allowed.
- Widths: index counter TBL_AW bits, never wraps past WORD_NUM-1. Frame bit counter sized to hold ADDR_W+DATA_W+1.

Test Plan:
- Default params, codec model echoes written registers; 4-entry table then 7'h7F terminator, entry0={7'h04,8'h15}:
  - first frame on DIN is 16'h0815, second is 16'h09FF;
  - oRD_DATA=8'h15 with oRD_VALID pulse;
  - oDONE after 4 entries, oERR=0.
- Model corrupts entry 2 readback twice, then correct (RETRY=2): 3 write frames for entry 2, oERR=0. Corrupt it 3 times: oERR=1, oERR_IDX=2, sequence continues to end.
- CLK_DIV=4: measure SCLK period = 8 iCLK_50 cycles, CS low for exactly 32 ticks per 16-bit frame, CS high >= 2 ticks between frames.
- VERIFY=0, WORD_NUM=3, no terminator: exactly 3 write frames, no read frames, oRD_VALID never pulses.
- Deassert iRESET_n during bit 7 of a frame: outputs return to reset values in the same cycle. iSTART afterwards restarts from index 0.
- iSTART pulsed while busy: no effect. iSTART after oDONE: oDONE clears, full sequence repeats.
